// File: rtl/operation_proj_bwn_incn_pkg.sv
`default_nettype none
// ============================================================================
// Module : operation_proj_bwn_incn_pkg
// Brief  : Shared state encoding and clog2 helper for the operation blocks.
// Rev    : 1.0
// ============================================================================
package operation_proj_bwn_incn_pkg;

  typedef enum logic {
    OP_IDLE = 1'b0,
    OP_BUSY = 1'b1
  } op_state_t;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/op_start_ctl.sv
`default_nettype none
// ============================================================================
// Module : op_start_ctl
// Brief  : ST edge detector, IDLE/BUSY state and fixed-latency counter.
// Rev    : 1.0
// ============================================================================
module op_start_ctl
  import operation_proj_bwn_incn_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic ST,
  output logic DONE_CNT,
  output logic ACCEPT,
  output logic BUSY,
  output logic RD,
  output logic OVR
);

  localparam int CW = clog2(LAT) + 1;

  op_state_t       r_state;
  op_state_t       w_state_nxt;
  logic            r_stold;
  logic [CW-1:0]   r_cnt;
  logic            w_edge;

  assign w_edge = ST & ~r_stold;
  assign BUSY   = (r_state == OP_BUSY);

  // Tracks ST even during reset so a held-high ST never looks like a new edge.
  always_ff @(posedge CLK) begin
    r_stold <= ST;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= OP_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    ACCEPT      = 1'b0;
    DONE_CNT    = 1'b0;
    case (r_state)
      OP_IDLE: begin
        if (w_edge) begin
          ACCEPT      = 1'b1;
          w_state_nxt = OP_BUSY;
        end
      end
      OP_BUSY: begin
        if (r_cnt == '0) begin
          DONE_CNT    = 1'b1;
          w_state_nxt = OP_IDLE;
        end
      end
      default: w_state_nxt = OP_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= '0;
      RD    <= 1'b1;
      OVR   <= 1'b0;
    end else if (ACCEPT) begin
      r_cnt <= CW'(LAT - 1);
      RD    <= 1'b0;
      OVR   <= 1'b0;
    end else if (BUSY) begin
      if (w_edge) begin
        OVR <= 1'b1;
      end
      if (DONE_CNT) begin
        RD <= 1'b1;
      end else begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/operation_proj_bwn_incn.sv
`default_nettype none
// ============================================================================
// Module : operation_proj_bwn_incn
// Brief  : Projection operation - returns operand SEL after LAT cycles.
// Rev    : 1.0
// ============================================================================
module operation_proj_bwn_incn
  import operation_proj_bwn_incn_pkg::*;
#(
  parameter int BW  = 16,
  parameter int N   = 3,
  parameter int SW  = 2,
  parameter int LAT = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            ST,
  input  logic [SW-1:0]   SEL,
  input  logic [N*BW-1:0] IN,
  output logic            RD,
  output logic [BW-1:0]   RES,
  output logic            ERR,
  output logic            OVR
);

  logic          w_accept;
  logic          w_done;
  logic          w_busy;
  logic          w_sel_ok;
  logic [BW-1:0] w_opnd;
  logic [BW-1:0] r_opnd;
  logic          r_bad;

  op_start_ctl #(
    .LAT (LAT)
  ) u_ctl (
    .CLK      (CLK),
    .RST      (RST),
    .ST       (ST),
    .DONE_CNT (w_done),
    .ACCEPT   (w_accept),
    .BUSY     (w_busy),
    .RD       (RD),
    .OVR      (OVR)
  );

  // N <= 2**SW, so N always fits in SW+1 bits.
  assign w_sel_ok = ({1'b0, SEL} < (SW + 1)'(N));

  always_comb begin
    w_opnd = '0;
    for (int k = 0; k < N; k++) begin
      if (SEL == SW'(k)) begin
        w_opnd = IN[k*BW +: BW];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_opnd <= '0;
      r_bad  <= 1'b0;
      RES    <= '0;
      ERR    <= 1'b0;
    end else if (w_accept) begin
      r_opnd <= w_sel_ok ? w_opnd : '0;
      r_bad  <= ~w_sel_ok;
      ERR    <= 1'b0;
    end else if (w_busy && w_done) begin
      RES <= r_bad ? '0 : r_opnd;
      ERR <= r_bad;
    end
  end

endmodule
`default_nettype wire
